regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
// - Integer register file for the RV32 core: 32 x 32-bit registers, two asynchronous read ports (rs1, rs2), one synchronous write port (dest).
// - Sits between decode (read operands) and writeback (dest). Register x0 is hardwired to zero.
// PARAMETERS
// - WIDTH       32  data width of each register and of every data port
// - REG_COUNT   32  number of architectural registers (x0..x31)
// - ADDR_WIDTH  5   register address width; REG_COUNT must equal 2**ADDR_WIDTH
// PORTS
// - clk        in   1           system clock; all state updates on rising edge
// - rst        in   1           synchronous, active-high reset
// - rs1_en     in   1           read port 1 enable
// - rs1_addr   in   ADDR_WIDTH  read port 1 register index
// - rs1_data   out  WIDTH       read port 1 data, combinational
// - rs2_en     in   1           read port 2 enable
// - rs2_addr   in   ADDR_WIDTH  read port 2 register index
// - rs2_data   out  WIDTH       read port 2 data, combinational
// - dest_en    in   1           write enable
// - dest_addr  in   ADDR_WIDTH  write register index
// - dest_data  in   WIDTH       write data
// - Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
// - Storage: array ram[0:REG_COUNT-1] of WIDTH bits.
// - Reset: on a rising clk with rst=1, every entry clears to 0. Any write in that same cycle is discarded. No reset on outputs, which are combinational.
// - Write: on a rising clk with rst=0 and dest_en=1, ram[dest_addr] <= dest_data. Write latency is 1 edge.
// - x0: writes with dest_addr=0 are ignored, so ram[0] stays 0. A read of address 0 always returns 0.
// - Read: rsN_data = (rsN_en && rsN_addr!=0) ? ram[rsN_addr] : 0. The read is purely combinational with zero-cycle latency.
// - Disabled read port (rsN_en=0) drives all zeros.
// - Both read ports are independent and may address the same register, including the dest register.
// - Read during write, same address, same cycle (default build): the read returns the OLD stored value. The new value becomes visible immediately after the clock edge.
// - Back-to-back writes to one register: the last write wins. A read in the following cycle returns the latest value.
// - No X propagation from unwritten entries after reset, because all entries are 0.
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: write-through bypass. If dest_en=1, dest_addr!=0, rst=0, rsN_en=1 and rsN_addr==dest_addr, then rsN_data=dest_data in the same cycle.
// - Undefined (default): no bypass. Reads return stored contents only, as above.
// STRUCTURE
// - Package regfile_pkg holds:
//   - constants WIDTH=32, REG_COUNT=32, ADDR_WIDTH=5
//   - typedef reg_addr_t = logic [ADDR_WIDTH-1:0]
//   - typedef reg_data_t = logic [WIDTH-1:0]
//   - constant ZERO_REG = 0
// - Sub-module regfile_rd_port handles one read port: the enable/x0 gating plus the optional bypass mux. It is instantiated twice.
// - Write logic and storage stay in the top module.
// TESTING
// - Reset: assert rst for 1 cycle after writing x5=0xDEADBEEF, then read x5 on both ports -> 0x00000000.
// - Basic write/read: write x1=0x12345678 (dest_en=1). Next cycle read rs1_addr=1 and rs2_addr=1 -> both 0x12345678.
// - x0: write x0=0xFFFFFFFF, then read x0 -> 0. Enable low: rs1_en=0 with rs1_addr=1 -> rs1_data=0.
// - Same-cycle read/write, x3 holding 0xAAAA0000: write x3=0x5555FFFF while rs1_addr=3.
//   - Default build: 0xAAAA0000 before the edge, 0x5555FFFF after it.
//   - With REGFILE_BYPASS_EN: 0x5555FFFF immediately.
// - Write disabled: dest_en=0 with dest_addr=7 and data 0x1 -> x7 unchanged.
// - Random pipeline, 128 cycles:
//   - Stimulus: random dest_addr/dest_data each cycle; rs1_addr = previous cycle's dest_addr; rs2_addr = previous cycle's rs1_addr.
//   - Check, rs1: rs1_data equals the data written 1 cycle earlier (0 if x0).
//   - Check, rs2: rs2_data equals the data written 2 cycles earlier, unless that register was rewritten in between; then the newer data.
//   - Required result: zero mismatches.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg: sizes, types and constants for the RV32 integer register file.
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// regfile_rd_port: one read port with enable/x0 gating and optional bypass mux.
// Rev 1.0 -- bypass compiled in only when REGFILE_BYPASS_EN is defined.
// ============================================================================
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic      rd_en,
  input  reg_addr_t rd_addr,
  input  reg_data_t ram_data,
  input  logic      byp_valid,
  input  reg_addr_t byp_addr,
  input  reg_data_t byp_data,
  output reg_data_t rd_data
);

  logic w_rd_active;
  assign w_rd_active = rd_en && (rd_addr != ZERO_REG);

`ifdef REGFILE_BYPASS_EN
  // byp_valid already excludes x0 writes and writes under reset.
  logic w_byp_hit;
  assign w_byp_hit = byp_valid && (rd_addr == byp_addr);

  always_comb begin
    rd_data = '0;
    if (w_rd_active) begin
      rd_data = w_byp_hit ? byp_data : ram_data;
    end
  end
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{byp_valid, byp_addr, byp_data};

  always_comb begin
    rd_data = '0;
    if (w_rd_active) begin
      rd_data = ram_data;
    end
  end
`endif

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// regfile: 32x32 RV32 register file, 2 async reads, 1 sync write, x0 = 0.
// Rev 1.0 -- define REGFILE_BYPASS_EN for same-cycle write-through reads.
// ============================================================================
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rs1_en,
  input  reg_addr_t rs1_addr,
  output reg_data_t rs1_data,
  input  logic      rs2_en,
  input  reg_addr_t rs2_addr,
  output reg_data_t rs2_data,
  input  logic      dest_en,
  input  reg_addr_t dest_addr,
  input  reg_data_t dest_data
);

  reg_data_t ram_q [0:REG_COUNT-1];
  reg_data_t ram_d [0:REG_COUNT-1];

  logic w_wr_valid;
  assign w_wr_valid = dest_en && !rst && (dest_addr != ZERO_REG);

  always_comb begin
    ram_d = ram_q;
    if (w_wr_valid) begin
      ram_d[dest_addr] = dest_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '{default: '0};
    end else begin
      ram_q <= ram_d;
    end
  end

  regfile_rd_port u_rd_port_rs1 (
    .rd_en     (rs1_en),
    .rd_addr   (rs1_addr),
    .ram_data  (ram_q[rs1_addr]),
    .byp_valid (w_wr_valid),
    .byp_addr  (dest_addr),
    .byp_data  (dest_data),
    .rd_data   (rs1_data)
  );

  regfile_rd_port u_rd_port_rs2 (
    .rd_en     (rs2_en),
    .rd_addr   (rs2_addr),
    .ram_data  (ram_q[rs2_addr]),
    .byp_valid (w_wr_valid),
    .byp_addr  (dest_addr),
    .byp_data  (dest_data),
    .rd_data   (rs2_data)
  );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// tb_regfile: directed and pipelined-random checks for the register file.
// Rev 1.0
// ============================================================================
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        rs1_en;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic        rs2_en;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        dest_en;
  logic [4:0]  dest_addr;
  logic [31:0] dest_data;

  int checks;
  int errors;

  logic [31:0] mdl [0:31];

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_en    (rs1_en),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs2_en    (rs2_en),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .dest_en   (dest_en),
    .dest_addr (dest_addr),
    .dest_data (dest_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    dest_en   = 1'b1;
    dest_addr = a;
    dest_data = d;
    tick();
    dest_en   = 1'b0;
  endtask

  task automatic test_reset;
    write_reg(5'd5, 32'hDEADBEEF);
    // Reset cycle also carries a write that must be discarded.
    rst       = 1'b1;
    dest_en   = 1'b1;
    dest_addr = 5'd6;
    dest_data = 32'hCAFEF00D;
    tick();
    rst       = 1'b0;
    dest_en   = 1'b0;
    rs1_en = 1'b1; rs1_addr = 5'd5;
    rs2_en = 1'b1; rs2_addr = 5'd5;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rs1_x5 got %h expected %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rs2_x5 got %h expected %h", rs2_data, 32'h0);
    end
    rs1_addr = 5'd6;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_discard got %h expected %h", rs1_data, 32'h0);
    end
  endtask

  task automatic test_basic;
    write_reg(5'd1, 32'h12345678);
    rs1_en = 1'b1; rs1_addr = 5'd1;
    rs2_en = 1'b1; rs2_addr = 5'd1;
    #1;
    checks++;
    if (rs1_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_rs1 got %h expected %h", rs1_data, 32'h12345678);
    end
    checks++;
    if (rs2_data !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_rs2 got %h expected %h", rs2_data, 32'h12345678);
    end
  endtask

  task automatic test_x0;
    rs1_en = 1'b1; rs1_addr = 5'd0;
    rs2_en = 1'b1; rs2_addr = 5'd0;
    dest_en = 1'b1; dest_addr = 5'd0; dest_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_during_write got %h expected %h", rs1_data, 32'h0);
    end
    tick();
    dest_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_rs1 got %h expected %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_rs2 got %h expected %h", rs2_data, 32'h0);
    end
  endtask

  task automatic test_enable;
    rs1_en = 1'b0; rs1_addr = 5'd1;
    rs2_en = 1'b1; rs2_addr = 5'd1;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL rs1_disabled got %h expected %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h12345678) begin
      errors++;
      $display("FAIL rs2_independent got %h expected %h", rs2_data, 32'h12345678);
    end
    rs1_en = 1'b1; rs2_en = 1'b0;
    #1;
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL rs2_disabled got %h expected %h", rs2_data, 32'h0);
    end
  endtask

  task automatic test_rw_same_cycle;
    logic [31:0] exp_before;
    write_reg(5'd3, 32'hAAAA0000);
    rs1_en = 1'b1; rs1_addr = 5'd3;
    dest_en = 1'b1; dest_addr = 5'd3; dest_data = 32'h5555FFFF;
`ifdef REGFILE_BYPASS_EN
    exp_before = 32'h5555FFFF;
`else
    exp_before = 32'hAAAA0000;
`endif
    #1;
    checks++;
    if (rs1_data !== exp_before) begin
      errors++;
      $display("FAIL rw_before_edge got %h expected %h", rs1_data, exp_before);
    end
    tick();
    dest_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h5555FFFF) begin
      errors++;
      $display("FAIL rw_after_edge got %h expected %h", rs1_data, 32'h5555FFFF);
    end
  endtask

  task automatic test_write_disabled;
    write_reg(5'd7, 32'h00000077);
    dest_en = 1'b0; dest_addr = 5'd7; dest_data = 32'h00000001;
    tick();
    rs2_en = 1'b1; rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs2_data !== 32'h00000077) begin
      errors++;
      $display("FAIL write_disabled got %h expected %h", rs2_data, 32'h00000077);
    end
  endtask

  task automatic test_back_to_back;
    dest_en = 1'b1; dest_addr = 5'd9; dest_data = 32'h11111111;
    tick();
    dest_data = 32'h22222222;
    tick();
    dest_en = 1'b0;
    rs1_en = 1'b1; rs1_addr = 5'd9;
    rs2_en = 1'b1; rs2_addr = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 32'h22222222) begin
      errors++;
      $display("FAIL b2b_rs1 got %h expected %h", rs1_data, 32'h22222222);
    end
    checks++;
    if (rs2_data !== 32'h22222222) begin
      errors++;
      $display("FAIL b2b_rs2 got %h expected %h", rs2_data, 32'h22222222);
    end
  endtask

  task automatic test_random_pipeline;
    logic [31:0] exp1;
    logic [31:0] exp2;
    rst = 1'b1; dest_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rs1_en = 1'b1; rs2_en = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    dest_addr = 5'd0;
    for (int c = 0; c < 128; c++) begin
      rs2_addr  = rs1_addr;
      rs1_addr  = dest_addr;
      dest_en   = 1'b1;
      dest_addr = 5'($urandom_range(0, 31));
      dest_data = $urandom;
      #1;
      exp1 = (rs1_addr == 5'd0) ? 32'h0 : mdl[rs1_addr];
      exp2 = (rs2_addr == 5'd0) ? 32'h0 : mdl[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (dest_addr != 5'd0 && rs1_addr == dest_addr) exp1 = dest_data;
      if (dest_addr != 5'd0 && rs2_addr == dest_addr) exp2 = dest_data;
`endif
      checks++;
      if (rs1_data !== exp1) begin
        errors++;
        $display("FAIL pipe_rs1 cyc %0d addr %0d got %h expected %h", c, rs1_addr, rs1_data, exp1);
      end
      checks++;
      if (rs2_data !== exp2) begin
        errors++;
        $display("FAIL pipe_rs2 cyc %0d addr %0d got %h expected %h", c, rs2_addr, rs2_data, exp2);
      end
      @(posedge clk);
      if (dest_addr != 5'd0) mdl[dest_addr] = dest_data;
      #1;
    end
    dest_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rs1_en = 1'b0; rs1_addr = '0;
    rs2_en = 1'b0; rs2_addr = '0;
    dest_en = 1'b0; dest_addr = '0; dest_data = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_x0();
    test_enable();
    test_rw_same_cycle();
    test_write_disabled();
    test_back_to_back();
    test_random_pipeline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_regfile
`default_nettype wire
